// File: rtl/gci_std_display_fifo_pkg.sv
// Shared definitions for the gci_std_display FIFO family.
//   fifo_ptr_width : pointer/count width from log2(depth); one extra bit tells full from empty.
//   SHOWAHEAD      : head word presented combinationally while not empty.
//   REGISTERED     : read data registered, valid one cycle after an accepted read.
package gci_std_display_fifo_pkg;

  localparam int unsigned SHOWAHEAD  = 1;
  localparam int unsigned REGISTERED = 0;

  function automatic int unsigned fifo_ptr_width(input int unsigned depth_n);
    return depth_n + 1;
  endfunction

endpackage

// File: rtl/gci_std_display_fifo_ram.sv
// Simple dual-port storage for the display FIFO: one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   iCLOCK  : write clock
//   iWE     : write enable
//   iWADDR  : write index
//   iWDATA  : write data
//   iRADDR  : read index
//   oRDATA  : read data (combinational)
module gci_std_display_fifo_ram #(
  parameter int unsigned P_N       = 16,
  parameter int unsigned P_DEPTH_N = 4
) (
  input  logic                 iCLOCK,
  input  logic                 iWE,
  input  logic [P_DEPTH_N-1:0] iWADDR,
  input  logic [P_N-1:0]       iWDATA,
  input  logic [P_DEPTH_N-1:0] iRADDR,
  output logic [P_N-1:0]       oRDATA
);

  localparam int unsigned Depth = 1 << P_DEPTH_N;

  logic [P_N-1:0] mem [Depth];

  always_ff @(posedge iCLOCK) begin
    if (iWE) begin
      mem[iWADDR] <= iWDATA;
    end
  end

  assign oRDATA = mem[iRADDR];

endmodule

// File: rtl/gci_std_display_prog_fifo.sv
// Synchronous FIFO with programmable full/empty thresholds for the display path.
// Optional sticky error flags are built when GCI_STD_DISPLAY_FIFO_ERRFLAG_EN is defined;
// otherwise oOVERFLOW/oUNDERFLOW are tied low.
//   iCLOCK/inRESET    : clock, asynchronous active-low reset
//   iREMOVE           : synchronous flush, overrides reads and writes
//   iWR_EN/iWR_DATA   : write request/data; oWR_FULL, oWR_PROG_FULL (count >= iPROG_FULL_TH)
//   iRD_EN            : read request; oRD_DATA/oRD_VALID read data and qualifier
//   oRD_EMPTY         : empty; oRD_PROG_EMPTY (count <= iPROG_EMPTY_TH)
//   oCOUNT            : occupancy
//   oOVERFLOW         : sticky write-while-full
//   oUNDERFLOW        : sticky read-while-empty
module gci_std_display_prog_fifo
  import gci_std_display_fifo_pkg::*;
#(
  parameter int unsigned P_N         = 16,
  parameter int unsigned P_DEPTH_N   = 4,
  parameter int unsigned P_SHOWAHEAD = SHOWAHEAD
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iREMOVE,
  input  logic               iWR_EN,
  input  logic [P_N-1:0]     iWR_DATA,
  output logic               oWR_FULL,
  output logic               oWR_PROG_FULL,
  input  logic [P_DEPTH_N:0] iPROG_FULL_TH,
  input  logic               iRD_EN,
  output logic [P_N-1:0]     oRD_DATA,
  output logic               oRD_VALID,
  output logic               oRD_EMPTY,
  output logic               oRD_PROG_EMPTY,
  input  logic [P_DEPTH_N:0] iPROG_EMPTY_TH,
  output logic [P_DEPTH_N:0] oCOUNT,
  output logic               oOVERFLOW,
  output logic               oUNDERFLOW
);

  localparam int unsigned W = fifo_ptr_width(P_DEPTH_N);
  localparam logic [W-1:0] DepthW = {1'b1, {P_DEPTH_N{1'b0}}};

  logic [W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0]   count;
  logic           full, empty;
  logic           wr_acc, rd_acc;
  logic [P_N-1:0] ram_rdata;

  // Extra pointer bit makes count == depth distinguishable from count == 0.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DepthW);
  assign empty = (count == '0);

  assign wr_acc = iWR_EN && !full;
  assign rd_acc = iRD_EN && !empty;

  assign oCOUNT         = count;
  assign oWR_FULL       = full;
  assign oRD_EMPTY      = empty;
  assign oWR_PROG_FULL  = (iPROG_FULL_TH == '0) || (count >= iPROG_FULL_TH);
  assign oRD_PROG_EMPTY = (iPROG_EMPTY_TH >= DepthW) || (count <= iPROG_EMPTY_TH);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (iREMOVE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + W'(1);
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  gci_std_display_fifo_ram #(
    .P_N       (P_N),
    .P_DEPTH_N (P_DEPTH_N)
  ) u_ram (
    .iCLOCK (iCLOCK),
    .iWE    (wr_acc && !iREMOVE),
    .iWADDR (wr_ptr_q[P_DEPTH_N-1:0]),
    .iWDATA (iWR_DATA),
    .iRADDR (rd_ptr_q[P_DEPTH_N-1:0]),
    .oRDATA (ram_rdata)
  );

  if (P_SHOWAHEAD == SHOWAHEAD) begin : g_showahead
    assign oRD_DATA  = ram_rdata;
    assign oRD_VALID = !empty;
  end else begin : g_registered
    logic [P_N-1:0] rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;

    // Data holds when no read is accepted, including during a flush.
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      if (!iREMOVE && rd_acc) begin
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
      end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign oRD_DATA  = rd_data_q;
    assign oRD_VALID = rd_valid_q;
  end

`ifdef GCI_STD_DISPLAY_FIFO_ERRFLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (iWR_EN && full);
    underflow_d = underflow_q | (iRD_EN && empty);
    if (iREMOVE) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign oOVERFLOW  = overflow_q;
  assign oUNDERFLOW = underflow_q;
`else
  assign oOVERFLOW  = 1'b0;
  assign oUNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_gci_std_display_prog_fifo.sv
// Bench for gci_std_display_prog_fifo: a show-ahead and a registered-read instance share
// stimulus and are compared against a queue-based reference model.
module tb_gci_std_display_prog_fifo;

  logic        iCLOCK;
  logic        inRESET;
  logic        iREMOVE;
  logic        iWR_EN;
  logic [15:0] iWR_DATA;
  logic        iRD_EN;
  logic [2:0]  iPROG_FULL_TH;
  logic [2:0]  iPROG_EMPTY_TH;

  logic        sa_full, sa_pfull, sa_valid, sa_empty, sa_pempty, sa_ovf, sa_unf;
  logic [15:0] sa_data;
  logic [2:0]  sa_count;
  logic        rg_full, rg_pfull, rg_valid, rg_empty, rg_pempty, rg_ovf, rg_unf;
  logic [15:0] rg_data;
  logic [2:0]  rg_count;

  gci_std_display_prog_fifo #(
    .P_N         (16),
    .P_DEPTH_N   (2),
    .P_SHOWAHEAD (1)
  ) u_dut_sa (
    .iCLOCK         (iCLOCK),
    .inRESET        (inRESET),
    .iREMOVE        (iREMOVE),
    .iWR_EN         (iWR_EN),
    .iWR_DATA       (iWR_DATA),
    .oWR_FULL       (sa_full),
    .oWR_PROG_FULL  (sa_pfull),
    .iPROG_FULL_TH  (iPROG_FULL_TH),
    .iRD_EN         (iRD_EN),
    .oRD_DATA       (sa_data),
    .oRD_VALID      (sa_valid),
    .oRD_EMPTY      (sa_empty),
    .oRD_PROG_EMPTY (sa_pempty),
    .iPROG_EMPTY_TH (iPROG_EMPTY_TH),
    .oCOUNT         (sa_count),
    .oOVERFLOW      (sa_ovf),
    .oUNDERFLOW     (sa_unf)
  );

  gci_std_display_prog_fifo #(
    .P_N         (16),
    .P_DEPTH_N   (2),
    .P_SHOWAHEAD (0)
  ) u_dut_rg (
    .iCLOCK         (iCLOCK),
    .inRESET        (inRESET),
    .iREMOVE        (iREMOVE),
    .iWR_EN         (iWR_EN),
    .iWR_DATA       (iWR_DATA),
    .oWR_FULL       (rg_full),
    .oWR_PROG_FULL  (rg_pfull),
    .iPROG_FULL_TH  (iPROG_FULL_TH),
    .iRD_EN         (iRD_EN),
    .oRD_DATA       (rg_data),
    .oRD_VALID      (rg_valid),
    .oRD_EMPTY      (rg_empty),
    .oRD_PROG_EMPTY (rg_pempty),
    .iPROG_EMPTY_TH (iPROG_EMPTY_TH),
    .oCOUNT         (rg_count),
    .oOVERFLOW      (rg_ovf),
    .oUNDERFLOW     (rg_unf)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [15:0] m_q[$];
  logic        m_ovf, m_unf;
  logic        m_rv;
  logic [15:0] m_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = 16'h0;
  endtask

  task automatic check_state();
    int n;
    logic eo, eu;
    n = m_q.size();
`ifdef GCI_STD_DISPLAY_FIFO_ERRFLAG_EN
    eo = m_ovf;
    eu = m_unf;
`else
    eo = 1'b0;
    eu = 1'b0;
`endif
    check_eq("count", 32'(sa_count), 32'(n));
    check_eq("rg_count", 32'(rg_count), 32'(n));
    check_eq("empty", 32'(sa_empty), 32'(n == 0));
    check_eq("full", 32'(sa_full), 32'(n == 4));
    check_eq("prog_full", 32'(sa_pfull), 32'(n >= int'(iPROG_FULL_TH)));
    check_eq("prog_empty", 32'(sa_pempty), 32'(n <= int'(iPROG_EMPTY_TH)));
    check_eq("sa_valid", 32'(sa_valid), 32'(n != 0));
    if (n != 0) check_eq("sa_head", 32'(sa_data), 32'(m_q[0]));
    check_eq("rg_valid", 32'(rg_valid), 32'(m_rv));
    check_eq("rg_data", 32'(rg_data), 32'(m_rd));
    check_eq("overflow", 32'(sa_ovf), 32'(eo));
    check_eq("underflow", 32'(sa_unf), 32'(eu));
    check_eq("rg_overflow", 32'(rg_ovf), 32'(eo));
    check_eq("rg_underflow", 32'(rg_unf), 32'(eu));
  endtask

  // One clock with the given request; the model advances using pre-edge occupancy.
  task automatic step(input logic wr, input logic [15:0] d, input logic rd, input logic rm);
    bit was_full, was_empty;
    iWR_EN   = wr;
    iWR_DATA = d;
    iRD_EN   = rd;
    iREMOVE  = rm;
    was_full  = (m_q.size() == 4);
    was_empty = (m_q.size() == 0);
    @(posedge iCLOCK);
    #1;
    if (rm) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      if (wr && was_full) m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
      m_rv = rd && !was_empty;
      if (m_rv) m_rd = m_q.pop_front();
      if (wr && !was_full) m_q.push_back(d);
    end
    iWR_EN  = 1'b0;
    iRD_EN  = 1'b0;
    iREMOVE = 1'b0;
    check_state();
  endtask

  initial begin
    logic [15:0] words [4];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    words[3] = 16'h4444;

    inRESET        = 1'b0;
    iREMOVE        = 1'b0;
    iWR_EN         = 1'b0;
    iWR_DATA       = 16'h0;
    iRD_EN         = 1'b0;
    iPROG_FULL_TH  = 3'd3;
    iPROG_EMPTY_TH = 3'd1;
    model_reset();
    #2;
    check_eq("rst_empty", 32'(sa_empty), 32'd1);
    check_eq("rst_rg_data", 32'(rg_data), 32'd0);
    check_state();
    #10;
    inRESET = 1'b1;
    @(posedge iCLOCK);
    #1;

    // Fill to full, then one dropped write.
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 1'b0, 1'b0);
    check_eq("fill_full", 32'(sa_full), 32'd1);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    // Simultaneous at full: pop 0x1111, write dropped.
    step(1'b1, 16'h6666, 1'b1, 1'b0);
    check_eq("full_rw_count", 32'(sa_count), 32'd3);
    check_eq("full_rw_popped", 32'(rg_data), 32'h1111);
    // Drain the rest in order.
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check_eq("drain_order", 32'(rg_data), 32'(words[i]));
    end
    // Simultaneous at empty: write accepted, read dropped.
    step(1'b1, 16'h7777, 1'b1, 1'b0);
    check_eq("empty_rw_count", 32'(sa_count), 32'd1);

    // Write/read pairs running the pointers through wrap.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'h0A00 + i), 1'b1, 1'b0);
      check_eq("wrap_cnt_le4", 32'(sa_count <= 3'd4), 32'd1);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // Registered-read latency.
    step(1'b1, 16'hABCD, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    check_eq("reg_valid", 32'(rg_valid), 32'd1);
    check_eq("reg_data", 32'(rg_data), 32'hABCD);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check_eq("reg_valid_1cyc", 32'(rg_valid), 32'd0);

    // Flush with a concurrent write.
    step(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hC000 + i), 1'b0, 1'b0);
    check_eq("pre_flush_cnt", 32'(sa_count), 32'd3);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1);
    check_eq("flush_cnt", 32'(sa_count), 32'd0);
    check_eq("flush_ovf", 32'(sa_ovf), 32'd0);

    // Asynchronous reset mid-write.
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    iWR_EN   = 1'b1;
    iWR_DATA = 16'hF00D;
    #3;
    inRESET = 1'b0;
    model_reset();
    #1;
    check_eq("arst_count", 32'(sa_count), 32'd0);
    check_eq("arst_rg_valid", 32'(rg_valid), 32'd0);
    check_state();
    @(posedge iCLOCK);
    #1;
    iWR_EN  = 1'b0;
    inRESET = 1'b1;
    check_state();
    step(1'b1, 16'h5A5A, 1'b0, 1'b0);
    check_eq("post_rst_head", 32'(sa_data), 32'h5A5A);

    // Random traffic with thresholds changing on the fly.
    for (int i = 0; i < 500; i++) begin
      if ((i % 16) == 0) begin
        iPROG_FULL_TH  = 3'($urandom_range(0, 7));
        iPROG_EMPTY_TH = 3'($urandom_range(0, 7));
        #1;
        check_state();
      end
      step(1'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
